// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit
// Pipeline hazard controller for the 5-stage MIPS core. Sits beside ID and
// drives the PC / IF_ID / ID_EX hold and flush controls.
//   - load-use hazards: LOAD_STALL bubbles per hazard, $zero never hazards,
//     each operand only counts when the ID instruction actually reads it
//   - taken branch (EX) and jump (ID) flushes
//   - whole-pipe freeze while memory is busy
//   - saturating statistics: stall cycles and flush events
//
// Ports
//   clk, reset          clock (rising edge), asynchronous active-low reset
//   ID_rs/ID_rt         source fields of the ID instruction
//   ID_uses_rs/rt       ID instruction reads rs / rt
//   ID_EX_MemRead/rt    EX instruction is a load, and its destination
//   branch_taken        branch resolved taken in EX
//   jump_id             jump decoded in ID
//   mem_busy            memory not ready, freeze the pipe
//   stat_clr            synchronous clear of the statistics counters
//   PCCont/IF_IDCont    hold PC / IF_ID
//   ID_EXCont           flush ID_EX (bubble)
//   IF_IDFlush          flush IF_ID
//   freeze              hold ID_EX, EX_MEM, MEM_WB
//   stall_cycles        cycles with PCCont=1 (saturating)
//   flush_events        cycles with IF_IDFlush=1 (saturating)
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | no bubbles owed; a load-use hit starts a hazard here
// LU_STALL | remaining bubbles of a multi-cycle hazard, cnt = bubbles left

module hazard_ctrl_unit #(
    parameter int REG_W      = 5,
    parameter int LOAD_STALL = 1,
    parameter int STAT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_W-1:0]  ID_rs,
    input  logic [REG_W-1:0]  ID_rt,
    input  logic              ID_uses_rs,
    input  logic              ID_uses_rt,
    input  logic              ID_EX_MemRead,
    input  logic [REG_W-1:0]  ID_EX_rt,
    input  logic              branch_taken,
    input  logic              jump_id,
    input  logic              mem_busy,
    input  logic              stat_clr,
    output logic              PCCont,
    output logic              IF_IDCont,
    output logic              ID_EXCont,
    output logic              IF_IDFlush,
    output logic              freeze,
    output logic [STAT_W-1:0] stall_cycles,
    output logic [STAT_W-1:0] flush_events
);

    localparam int CNT_W = $clog2(LOAD_STALL + 1);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(LOAD_STALL - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [STAT_W-1:0] STAT_ONE = STAT_W'(1);
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    typedef enum logic {
        IDLE     = 1'b0,
        LU_STALL = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [STAT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [STAT_W-1:0] flush_events_q, flush_events_d;

    logic lu_hit;
    logic pc_c, if_id_c, id_ex_c, flush_c, freeze_c;

    assign lu_hit = ID_EX_MemRead && (ID_EX_rt != '0) &&
                    ((ID_uses_rs && (ID_EX_rt == ID_rs)) ||
                     (ID_uses_rt && (ID_EX_rt == ID_rt)));

    always_comb begin
        pc_c     = 1'b0;
        if_id_c  = 1'b0;
        id_ex_c  = 1'b0;
        flush_c  = 1'b0;
        freeze_c = 1'b0;
        state_d  = state_q;
        cnt_d    = cnt_q;

        if (mem_busy) begin
            // whole pipe holds; the hazard sequence is paused, not consumed
            freeze_c = 1'b1;
            pc_c     = 1'b1;
            if_id_c  = 1'b1;
        end else if (branch_taken) begin
            // the stalled instruction is on the wrong path, so drop the hazard
            flush_c  = 1'b1;
            id_ex_c  = 1'b1;
            state_d  = IDLE;
            cnt_d    = '0;
        end else if (state_q == LU_STALL) begin
            pc_c    = 1'b1;
            if_id_c = 1'b1;
            id_ex_c = 1'b1;
            if (cnt_q == CNT_ONE) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end else if (lu_hit) begin
            // first bubble is issued from IDLE; only the rest need LU_STALL
            pc_c    = 1'b1;
            if_id_c = 1'b1;
            id_ex_c = 1'b1;
            if (LOAD_STALL > 1) begin
                state_d = LU_STALL;
                cnt_d   = CNT_LOAD;
            end
        end else if (jump_id) begin
            flush_c = 1'b1;
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_events_d = flush_events_q;
        if (stat_clr) begin
            stall_cycles_d = '0;
            flush_events_d = '0;
        end else begin
            if (pc_c && (stall_cycles_q != STAT_MAX)) begin
                stall_cycles_d = stall_cycles_q + STAT_ONE;
            end
            if (flush_c && (flush_events_q != STAT_MAX)) begin
                flush_events_d = flush_events_q + STAT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    // controls are gated by reset so the pipe sees no hold/flush while in reset
    assign PCCont       = reset & pc_c;
    assign IF_IDCont    = reset & if_id_c;
    assign ID_EXCont    = reset & id_ex_c;
    assign IF_IDFlush   = reset & flush_c;
    assign freeze       = reset & freeze_c;
    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;

endmodule
